// File: rtl/key_matrix_scan.sv
// 4x4 matrix keypad scanner with press/release debounce.
// Emits a single-cycle key_vld strobe with key_num = 4*row + col per debounced press.
module key_matrix_scan #(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int SCAN_CYC     = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_col,
  output logic [3:0] key_row,
  output logic [3:0] key_num,
  output logic       key_vld
);

  localparam int CNT_MAX = (DEBOUNCE_CYC > SCAN_CYC) ? DEBOUNCE_CYC : SCAN_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_PRESS_DB   = 3'd1;
  localparam logic [2:0] S_SCAN       = 3'd2;
  localparam logic [2:0] S_REPORT     = 3'd3;
  localparam logic [2:0] S_RELEASE_DB = 3'd4;

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       row_idx;
  logic [3:0]       col_m;
  logic [3:0]       col_s;

  // Lowest-index low column wins when several keys share a row.
  function automatic logic [1:0] low_col(input logic [3:0] col);
    if (!col[0])      return 2'd0;
    else if (!col[1]) return 2'd1;
    else if (!col[2]) return 2'd2;
    else              return 2'd3;
  endfunction

  function automatic logic [3:0] row_drive(input logic [1:0] r);
    return ~(4'b0001 << r);
  endfunction

  // Column synchroniser; idle lines read as released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_m <= 4'hF;
      col_s <= 4'hF;
    end else begin
      col_m <= key_col;
      col_s <= col_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      row_idx <= '0;
      key_row <= 4'b0000;
      key_num <= '0;
      key_vld <= 1'b0;
    end else begin
      key_vld <= 1'b0;
      case (state)
        S_IDLE: begin
          key_row <= 4'b0000;
          if (col_s != 4'hF) begin
            state <= S_PRESS_DB;
            cnt   <= '0;
          end
        end
        S_PRESS_DB: begin
          key_row <= 4'b0000;
          if (col_s == 4'hF) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state   <= S_SCAN;
            cnt     <= '0;
            row_idx <= 2'd0;
            key_row <= row_drive(2'd0);
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_SCAN: begin
          if (cnt == SCAN_LAST) begin
            cnt <= '0;
            if (col_s != 4'hF) begin
              key_num <= {row_idx, low_col(col_s)};
              key_vld <= 1'b1;
              key_row <= 4'b0000;
              state   <= S_REPORT;
            end else if (row_idx != 2'd3) begin
              row_idx <= row_idx + 2'd1;
              key_row <= row_drive(row_idx + 2'd1);
            end else begin
              // Key let go before its row came round: drop it silently.
              key_row <= 4'b0000;
              state   <= S_IDLE;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_REPORT: begin
          key_row <= 4'b0000;
          cnt     <= '0;
          state   <= S_RELEASE_DB;
        end
        S_RELEASE_DB: begin
          key_row <= 4'b0000;
          if (col_s != 4'hF) begin
            cnt <= '0;
          end else if (cnt == DB_LAST) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state   <= S_IDLE;
          cnt     <= '0;
          row_idx <= '0;
          key_row <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: doc/key_matrix_scan.md
Name: key_matrix_scan

Overview:
- Scans and debounces a 4x4 matrix keypad. Produces the `key_num`/`key_vld` event stream consumed by the key configuration block (`reset`, `en_coms` and `value_gray` control).
- Drives the row lines active-low and reads the column lines. Column lines are pulled up externally.
- Emits exactly one single-cycle `key_vld` pulse per debounced press.

Parameters:
- DEBOUNCE_CYC, default 1000000: stable cycles required for press and release (20 ms at 50 MHz). Minimum 2.
- SCAN_CYC, default 500: cycles each row is driven before its columns are sampled. Covers line settling plus the 2-FF synchroniser. Minimum 4.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- key_col  in  4  keypad column lines, active-low, asynchronous to clk
- key_row  out  4  keypad row drive, active-low
- key_num  out  4  code of the last detected key, equal to 4*row + col
- key_vld  out  1  one-cycle strobe; key_num is valid in the same cycle

Behaviour:
- Reset values: key_row=4'b0000, key_num=0, key_vld=0, state=IDLE, counters=0, row index=0. Reset is asynchronous and immediate from any state, including mid-debounce or mid-scan.
- key_col passes through a 2-FF synchroniser; its reset value is 4'hF. All decisions use the synchronised value col_s.
- All outputs are registered.
- IDLE:
  - key_row=4'b0000, so every row is driven.
  - When col_s != 4'hF: go to PRESS_DB, cnt=0.
- PRESS_DB:
  - key_row=4'b0000.
  - If col_s==4'hF: go to IDLE with no output. This is bounce rejection.
  - Otherwise cnt increments. When cnt==DEBOUNCE_CYC-1: go to SCAN with row index r=0 and cnt=0.
- SCAN:
  - key_row = ~(4'b0001<<r). cnt counts 0..SCAN_CYC-1.
  - At cnt==SCAN_CYC-1, sample col_s:
    - Any bit low: c = lowest-index low bit; latch key_num=4*r+c; go to REPORT.
    - All high and r<3: r increments, cnt=0.
    - All high and r==3: go to IDLE with no output. The key was released during the scan.
  - Several keys on one row: the lowest column wins.
  - Keys on different rows: the lowest row wins, because it is scanned first.
- REPORT:
  - Lasts exactly 1 cycle. key_vld=1 and key_num holds the new code.
  - key_row=4'b0000. Then go to RELEASE_DB, cnt=0.
- RELEASE_DB:
  - key_row=4'b0000.
  - If col_s != 4'hF: cnt=0, stay.
  - Otherwise cnt increments. When cnt==DEBOUNCE_CYC-1: go to IDLE.
  - A held key therefore never generates a second pulse. Release bounce only restarts the count.
- key_vld is 0 in every state except REPORT. key_num holds its value until the next REPORT.
- Latency from a clean press at the pins to key_vld: 2 (sync) + 1 (IDLE detect) + DEBOUNCE_CYC + (r+1)*SCAN_CYC + 1 cycles, ±1 for sampling phase. The bench checks a ±2 cycle window.
- Counter width: clog2(max(DEBOUNCE_CYC, SCAN_CYC)) bits; it never wraps.
- No other state is reachable. Any illegal encoding returns to IDLE.

Test Plan:
Bench settings: DEBOUNCE_CYC=16, SCAN_CYC=4. The keypad model ties key_col[c] to key_row[r] while key (r,c) is pressed and pulls key_col high otherwise.
1. Press (1,0) clean and hold 300 cycles -> exactly one key_vld pulse with key_num=4, at about 2+1+16+8+1 = 28 cycles after press. key_row returns to 0000; no further pulse.
2. Press (2,3) for 6 cycles, then release -> no key_vld; state back to IDLE; key_num keeps its previous value.
3. Press (2,1), hold 100, release 100, press (0,0) -> pulses with key_num=9, then key_num=0.
4. Press (3,2) and (3,3) together -> single pulse, key_num=14. Press (0,1) and (3,3) together -> single pulse, key_num=1.
5. Press (3,0) for exactly 2+1+16+2 cycles, so it releases during the row-0 scan -> no pulse.
6. Release-bounce check and reset check:
   - After a pulse for (1,1)=5, toggle the key 3 times with 5-cycle gaps, then release -> no second pulse; return to IDLE 16 cycles after the final release.
   - Assert rst_n low during PRESS_DB -> key_vld=0, key_num=0, key_row=0000 immediately. After rst_n rises, pressing (0,2) gives key_num=2.
